// File: rtl/exec_wb_lane_pipe.sv
// One 16-bit execution lane: S1 input capture, S2 compute, output register.
// An op accepted at edge N is presented on the outputs after edge N+2.
module exec_wb_lane_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_opcode,
    input  logic [7:0]       in_imm,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_x,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             out_wen,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg
);

    localparam logic [3:0] OP_MOVL = 4'b0100;
    localparam logic [3:0] OP_MOVH = 4'b0101;

    logic             s1_valid;
    logic [3:0]       s1_opcode;
    logic [7:0]       s1_imm;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_x;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic             s2_wen;
    logic [WIDTH-1:0] s2_result;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH-1:0] alu_result;
    logic             alu_wen;

    // opcode[3] only selects scalar vs vector; the per-element arithmetic is identical.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        alu_result = s1_a;
        alu_wen    = 1'b0;
        if (!s1_opcode[2]) begin
            alu_wen = 1'b1;
            unique case (s1_opcode[1:0])
                2'd0: alu_result = s1_a + s1_x;
                2'd1: alu_result = s1_a - s1_x;
                2'd2: alu_result = s1_a * s1_x;
                2'd3: alu_result = (s1_x == '0) ? '1 : s1_a / s1_x;
            endcase
        end else if (s1_opcode == OP_MOVL) begin
            alu_wen    = 1'b1;
            alu_result = WIDTH'($signed(s1_imm));
        end else if (s1_opcode == OP_MOVH) begin
            alu_wen    = 1'b1;
            alu_result = WIDTH'({s1_imm, s1_x[7:0]});
        end
    end

    // NOTE: non-blocking assignments so every stage samples the previous-cycle value of the one before it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_opcode  <= '0;
            s1_imm     <= '0;
            s1_a       <= '0;
            s1_x       <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_wen     <= 1'b0;
            s2_result  <= '0;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_wen    <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            // Flush wins over stall; data registers keep stale values behind cleared valids.
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_opcode  <= in_opcode;
            s1_imm     <= in_imm;
            s1_a       <= in_a;
            s1_x       <= in_x;
            s1_tag     <= in_tag;
            s2_valid   <= s1_valid;
            s2_wen     <= s1_valid & alu_wen;
            s2_result  <= alu_result;
            s2_tag     <= s1_tag;
            out_valid  <= s2_valid;
            out_wen    <= s2_valid & s2_wen;
            out_result <= s2_result;
            out_tag    <= s2_tag;
        end
    end

    assign out_zero = out_valid & (out_result == '0);
    assign out_neg  = out_valid & out_result[WIDTH-1];

endmodule

// File: tb/tb_exec_wb_lane_pipe.sv
// Bench for exec_wb_lane_pipe: directed spec cases then random ops with stall/flush/reset,
// checked against a transaction-level model that computes results at acceptance time.
module tb_exec_wb_lane_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_opcode = '0;
    logic [7:0]  in_imm = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_x = '0;
    logic [7:0]  in_tag = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_wen;
    logic [15:0] out_result;
    logic [7:0]  out_tag;
    logic        out_zero;
    logic        out_neg;

    exec_wb_lane_pipe #(.WIDTH(16), .TAG_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_imm     (in_imm),
        .in_a       (in_a),
        .in_x       (in_x),
        .in_tag     (in_tag),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_wen    (out_wen),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_neg    (out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          wen;
        bit          known;
        int unsigned result;
        int unsigned tag;
    } exp_t;

    // pending[0] is the op accepted most recently; an op needs two unstalled edges to reach m_out.
    exp_t pending [2];
    exp_t m_out;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input int unsigned imm, input int unsigned a,
                                   input int unsigned x, output int unsigned r, output bit w);
        w = 1'b1;
        r = a;
        if (op[2] == 1'b0) begin
            case (op[1:0])
                2'd0: r = (a + x) % 65536;
                2'd1: r = (a + 65536 - x) % 65536;
                2'd2: r = int'((longint'(a) * longint'(x)) % 65536);
                default: r = (x == 0) ? 65535 : a / x;
            endcase
        end else if (op == 4'b0100) begin
            r = (imm >= 128) ? imm + 65280 : imm;
        end else if (op == 4'b0101) begin
            r = imm * 256 + x % 256;
        end else begin
            w = 1'b0;
        end
    endfunction

    function automatic exp_t empty_slot();
        exp_t e;
        e.valid = 1'b0; e.wen = 1'b0; e.known = 1'b0; e.result = 0; e.tag = 0;
        return e;
    endfunction

    task automatic compare_all();
        bit exp_zero;
        bit exp_neg;
        exp_zero = m_out.valid && (m_out.result == 0);
        exp_neg  = m_out.valid && (m_out.result >= 32768);
        check("out_valid", 32'(out_valid), 32'(m_out.valid));
        check("out_wen", 32'(out_wen), 32'(m_out.valid & m_out.wen));
        check("out_zero", 32'(out_zero), 32'(exp_zero));
        check("out_neg", 32'(out_neg), 32'(exp_neg));
        if (m_out.known) begin
            check("out_result", 32'(out_result), m_out.result);
            check("out_tag", 32'(out_tag), m_out.tag);
        end
    endtask

    task automatic step(input bit v, input logic [3:0] op, input logic [7:0] imm, input logic [15:0] a,
                        input logic [15:0] x, input logic [7:0] tag, input bit st, input bit fl, input bit rs);
        exp_t acc;
        in_valid = v; in_opcode = op; in_imm = imm; in_a = a; in_x = x; in_tag = tag;
        stall = st; flush = fl; reset = rs;
        @(posedge clk);
        if (rs) begin
            pending[0] = empty_slot();
            pending[1] = empty_slot();
            m_out = empty_slot();
            m_out.known = 1'b1;
        end else if (fl) begin
            pending[0] = empty_slot();
            pending[1] = empty_slot();
            m_out = empty_slot();
        end else if (!st) begin
            acc = empty_slot();
            if (v) begin
                acc.valid = 1'b1;
                acc.known = 1'b1;
                acc.tag   = tag;
                ref_op(op, imm, a, x, acc.result, acc.wen);
            end
            m_out      = pending[1];
            pending[1] = pending[0];
            pending[0] = acc;
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 8'h00, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [3:0] opc, input logic [7:0] imm, input logic [15:0] a,
                      input logic [15:0] x, input logic [7:0] tag);
        step(1'b1, opc, imm, a, x, tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pending[0] = empty_slot();
        pending[1] = empty_slot();
        m_out = empty_slot();

        // Reset held for two cycles.
        step(1'b0, 4'h0, 8'h00, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 8'h00, 16'h0, 16'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("reset_result", 32'(out_result), 32'h0);
        check("reset_tag", 32'(out_tag), 32'h0);

        // add 3+4, tag 5.
        op(4'h0, 8'h00, 16'd3, 16'd4, 8'd5);
        idle();
        check("add_not_yet", 32'(out_valid), 32'h0);
        idle();
        check("add_result", 32'(out_result), 32'd7);
        check("add_tag", 32'(out_tag), 32'd5);

        // Back-to-back sub, mul, div-by-zero.
        op(4'h1, 8'h00, 16'd5, 16'd5, 8'd1);
        op(4'h2, 8'h00, 16'h0100, 16'h0100, 8'd2);
        op(4'hB, 8'h00, 16'd7, 16'd0, 8'd3);
        check("sub_zero", 32'(out_zero), 32'h1);
        idle();
        check("mul_result", 32'(out_result), 32'h0000);
        idle();
        check("div0_result", 32'(out_result), 32'hFFFF);
        check("div0_wen", 32'(out_wen), 32'h1);

        // movl, movh, pass-through opcode.
        op(4'h4, 8'h80, 16'h0000, 16'h0000, 8'd10);
        op(4'h5, 8'h12, 16'h0000, 16'h0034, 8'd11);
        op(4'h6, 8'h00, 16'hBEEF, 16'h0000, 8'd12);
        check("movl_result", 32'(out_result), 32'hFF80);
        check("movl_neg", 32'(out_neg), 32'h1);
        idle();
        check("movh_result", 32'(out_result), 32'h1234);
        idle();
        check("pass_valid", 32'(out_valid), 32'h1);
        check("pass_wen", 32'(out_wen), 32'h0);
        check("pass_result", 32'(out_result), 32'hBEEF);

        // Stall for three cycles with an op sitting in S1; stalled inputs must be ignored.
        op(4'h0, 8'h00, 16'd1, 16'd1, 8'd20);
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'h1, 8'h00, 16'd9, 16'd1, 8'd99, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        check("stall_result", 32'(out_result), 32'd2);
        check("stall_tag", 32'(out_tag), 32'd20);
        idle();
        check("stall_no_extra", 32'(out_valid), 32'h0);

        // Flush with two ops in flight and a new op offered on the same edge.
        op(4'h0, 8'h00, 16'd1, 16'd2, 8'd30);
        op(4'h0, 8'h00, 16'd3, 16'd4, 8'd31);
        step(1'b1, 4'h0, 8'h00, 16'd5, 16'd6, 8'd32, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("flush_quiet", 32'(out_valid), 32'h0);
        end

        // Flush takes priority over stall.
        op(4'h0, 8'h00, 16'd1, 16'd1, 8'd40);
        step(1'b1, 4'h0, 8'h00, 16'd2, 16'd2, 8'd41, 1'b1, 1'b1, 1'b0);
        idle();
        idle();
        check("flush_over_stall", 32'(out_valid), 32'h0);

        // Reset mid-stream, then first op emerges two edges after acceptance.
        op(4'h0, 8'h00, 16'd8, 16'd8, 8'd50);
        op(4'h0, 8'h00, 16'd9, 16'd9, 8'd51);
        step(1'b1, 4'h0, 8'h00, 16'd1, 16'd1, 8'd52, 1'b0, 1'b0, 1'b1);
        op(4'h1, 8'h00, 16'd10, 16'd3, 8'd53);
        idle();
        check("post_reset_quiet", 32'(out_valid), 32'h0);
        idle();
        check("post_reset_result", 32'(out_result), 32'd7);

        // Randomized traffic including occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom), 8'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
